// File: rtl/hazard_pkg.sv
// Shared defaults and stall-cause encoding for the hazard scoreboard.
// Imported by the scoreboard top, its per-register entry and the interface.
package hazard_pkg;

  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_LAT_W   = 3;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    STALL_NONE = 2'b00,
    STALL_RAW  = 2'b01,
    STALL_WAW  = 2'b10,
    STALL_BOTH = 2'b11
  } stall_cause_e;

  function automatic stall_cause_e stall_cause(
    input logic raw,
    input logic waw
  );
    return stall_cause_e'({waw, raw});
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue/write-back bundle between the decode stage and the
// hazard scoreboard; clk/rst stay outside as plain ports.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_SRC*ADDR_W-1:0] rs_addr_i;
  logic [NUM_SRC-1:0]        rs_used_i;
  logic                      issue_valid_i;
  logic                      issue_wr_sig_i;
  logic [ADDR_W-1:0]         issue_rd_addr_i;
  logic [LAT_W-1:0]          issue_lat_i;
  logic                      wb_valid_i;
  logic [ADDR_W-1:0]         wb_addr_i;
  logic                      stall_o;
  logic [NUM_SRC-1:0]        fwd_valid_o;
  logic [NUM_REGS-1:0]       busy_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  modport master (
    output rs_addr_i, rs_used_i,
    output issue_valid_i, issue_wr_sig_i,
    output issue_rd_addr_i, issue_lat_i,
    output wb_valid_i, wb_addr_i,
    input  stall_o, fwd_valid_o,
    input  busy_o, stall_cnt_o
  );

  modport slave (
    input  rs_addr_i, rs_used_i,
    input  issue_valid_i, issue_wr_sig_i,
    input  issue_rd_addr_i, issue_lat_i,
    input  wb_valid_i, wb_addr_i,
    output stall_o, fwd_valid_o,
    output busy_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One register's pending bit and forwarding countdown.
// Priority: issue load, then write-back clear, then countdown.
module scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             clr_i,
  output logic             pend_o,
  output logic [LAT_W-1:0] cnt_o
);

  logic             pend_q, pend_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // next state: a new issue beats a same-cycle write-back
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      pend_d = 1'b1;
      cnt_d  = lat_i;
    end else if (clr_i) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // state register, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: RAW/WAW stall, bypass select,
// per-register busy bits and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic          clk_i,
  input logic          rst_i,
  hazard_scoreboard_if.slave sb_if
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic             pend [NUM_REGS];
  logic [LAT_W-1:0] cnt  [NUM_REGS];

  logic [NUM_SRC-1:0]  raw;
  logic [NUM_SRC-1:0]  fwd;
  logic [ADDR_W-1:0]   rs;
  logic                hit;
  logic                waw;
  logic                stall;
  logic                accept;
  stall_cause_e        cause;
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // x0 is hardwired, never pending
  assign pend[0] = 1'b0;
  assign cnt[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    logic ld;
    logic cl;
    assign ld = accept && sb_if.issue_wr_sig_i
             && (sb_if.issue_rd_addr_i == ADDR_W'(r));
    assign cl = sb_if.wb_valid_i
             && (sb_if.wb_addr_i == ADDR_W'(r));
    scoreboard_entry #(.LAT_W(LAT_W)) u_ent (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (ld),
      .lat_i  (sb_if.issue_lat_i),
      .clr_i  (cl),
      .pend_o (pend[r]),
      .cnt_o  (cnt[r])
    );
  end

  // per-channel RAW stall vs. bypass: pending and still counting stalls
  always_comb begin
    raw = '0;
    fwd = '0;
    rs  = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs  = sb_if.rs_addr_i[k*ADDR_W +: ADDR_W];
      hit = sb_if.rs_used_i[k] && (rs != '0) && pend[rs];
      raw[k] = hit && (cnt[rs] != '0);
      fwd[k] = hit && (cnt[rs] == '0);
    end
  end

  // conservative stall: a same-cycle write-back does not release it
  always_comb begin
    waw = sb_if.issue_valid_i && sb_if.issue_wr_sig_i
       && (sb_if.issue_rd_addr_i != '0)
       && pend[sb_if.issue_rd_addr_i];
    cause  = stall_cause(|raw, waw);
    stall  = sb_if.issue_valid_i && (cause != STALL_NONE);
    accept = sb_if.issue_valid_i && !stall;
  end

  // busy vector straight from the registered pending bits
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = pend[r];
    end
  end

  // stall counter next value, holds at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // stall counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_if.stall_o     = stall;
  assign sb_if.fwd_valid_o = fwd;
  assign sb_if.busy_o      = busy;
  assign sb_if.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: random and directed decode traffic against a
// cycle-stamp reference model; two builds (CNT_W=16 and CNT_W=4).
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.CNT_W(16)) bus_a ();
  hazard_scoreboard_if #(.CNT_W(4))  bus_b ();

  hazard_scoreboard #(.CNT_W(16)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .sb_if (bus_a.slave)
  );

  hazard_scoreboard #(.CNT_W(4)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .sb_if (bus_b.slave)
  );

  typedef struct {
    logic        stall;
    logic [1:0]  fwd;
    logic [31:0] busy;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  bit   done = 0;

  // reference model: pending flag plus the absolute cycle when the
  // value becomes forwardable
  bit     m_pend [32];
  longint m_fwd_at [32];
  longint cyc = 0;
  int     m_cnt = 0;
  int     m_cnt_s = 0;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r]   = 0;
      m_fwd_at[r] = 0;
    end
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  task automatic drive(
    input bit iv, input bit wr, input int rd, input int lat,
    input bit wbv, input int wba,
    input int ra0, input bit u0, input int ra1, input bit u1,
    input bit r
  );
    exp_t e;
    bit raw_any;
    bit waw;
    int ra[2];
    bit us[2];
    @(posedge clk);
    #1;
    rst = r;
    bus_a.issue_valid_i   = iv;
    bus_a.issue_wr_sig_i  = wr;
    bus_a.issue_rd_addr_i = 5'(rd);
    bus_a.issue_lat_i     = 3'(lat);
    bus_a.wb_valid_i      = wbv;
    bus_a.wb_addr_i       = 5'(wba);
    bus_a.rs_addr_i       = {5'(ra1), 5'(ra0)};
    bus_a.rs_used_i       = {u1, u0};
    bus_b.issue_valid_i   = iv;
    bus_b.issue_wr_sig_i  = wr;
    bus_b.issue_rd_addr_i = 5'(rd);
    bus_b.issue_lat_i     = 3'(lat);
    bus_b.wb_valid_i      = wbv;
    bus_b.wb_addr_i       = 5'(wba);
    bus_b.rs_addr_i       = {5'(ra1), 5'(ra0)};
    bus_b.rs_used_i       = {u1, u0};
    if (r) begin
      model_reset();
      e.stall = 0;
      e.fwd   = 0;
      e.busy  = 0;
      e.cnt   = 0;
      e.cnt_s = 0;
      q.push_back(e);
      cyc++;
      return;
    end
    ra[0] = ra0; ra[1] = ra1;
    us[0] = u0;  us[1] = u1;
    raw_any = 0;
    e.fwd = 0;
    for (int k = 0; k < 2; k++) begin
      if (us[k] && ra[k] != 0 && m_pend[ra[k]]) begin
        if (cyc < m_fwd_at[ra[k]]) raw_any = 1;
        else e.fwd[k] = 1'b1;
      end
    end
    waw = iv && wr && rd != 0 && m_pend[rd];
    e.stall = iv && (raw_any || waw);
    e.busy = 0;
    for (int i = 1; i < 32; i++) e.busy[i] = m_pend[i];
    e.cnt   = 16'(m_cnt);
    e.cnt_s = 4'(m_cnt_s);
    q.push_back(e);
    if (e.stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
    end
    if (wbv && wba != 0) m_pend[wba] = 0;
    if (iv && !e.stall && wr && rd != 0) begin
      m_pend[rd]   = 1;
      m_fwd_at[rd] = cyc + lat + 1;
    end
    cyc++;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: every cycle the DUT presents a fresh output set
  always @(negedge clk) begin
    exp_t e;
    if (!done && q.size() > 0) begin
      e = q.pop_front();
      nvec++;
      if (bus_a.stall_o !== e.stall) begin
        nmis++;
        $display("FAIL stall t=%0t got %b want %b", $time, bus_a.stall_o, e.stall);
      end
      if (bus_a.fwd_valid_o !== e.fwd) begin
        nmis++;
        $display("FAIL fwd t=%0t got %b want %b", $time, bus_a.fwd_valid_o, e.fwd);
      end
      if (bus_a.busy_o !== e.busy) begin
        nmis++;
        $display("FAIL busy t=%0t got %h want %h", $time, bus_a.busy_o, e.busy);
      end
      if (bus_a.stall_cnt_o !== e.cnt) begin
        nmis++;
        $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, bus_a.stall_cnt_o, e.cnt);
      end
      if (bus_b.stall_cnt_o !== e.cnt_s) begin
        nmis++;
        $display("FAIL stall_cnt_w4 t=%0t got %0d want %0d", $time, bus_b.stall_cnt_o, e.cnt_s);
      end
      if (bus_b.stall_o !== e.stall || bus_b.fwd_valid_o !== e.fwd || bus_b.busy_o !== e.busy) begin
        nmis++;
        $display("FAIL w4_outputs t=%0t got %b/%b/%h want %b/%b/%h", $time,
                 bus_b.stall_o, bus_b.fwd_valid_o, bus_b.busy_o, e.stall, e.fwd, e.busy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", nvec);
    $fatal(1);
  end

  initial begin
    model_reset();
    bus_a.issue_valid_i = 0; bus_a.issue_wr_sig_i = 0;
    bus_a.issue_rd_addr_i = 0; bus_a.issue_lat_i = 0;
    bus_a.wb_valid_i = 0; bus_a.wb_addr_i = 0;
    bus_a.rs_addr_i = 0; bus_a.rs_used_i = 0;
    bus_b.issue_valid_i = 0; bus_b.issue_wr_sig_i = 0;
    bus_b.issue_rd_addr_i = 0; bus_b.issue_lat_i = 0;
    bus_b.wb_valid_i = 0; bus_b.wb_addr_i = 0;
    bus_b.rs_addr_i = 0; bus_b.rs_used_i = 0;

    // reset with demanding inputs: outputs must stay quiet
    drive(1, 1, 5, 2, 0, 0, 5, 1, 5, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1);
    idle();

    // rd=5 lat=2: two RAW stall cycles, then bypass
    drive(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    idle();

    // rd=7 lat=0: forwards next cycle on channel 1
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0);
    drive(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    idle();

    // WAW with same-cycle write-back still stalls
    drive(1, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 9, 1, 1, 9, 0, 0, 0, 0, 0);
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 9, 1, 9, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 9, 1, 9, 1, 0);
    drive(1, 1, 12, 2, 1, 12, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 9, 0, 0, 12, 1, 0);
    idle();

    // x0 as destination and source
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    idle();

    // reset mid-countdown discards rd=3
    drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    drive(1, 1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);

    // repeated RAW windows push the 4-bit counter into saturation
    for (int n = 0; n < 4; n++) begin
      drive(1, 1, 10, 7, 0, 0, 0, 0, 0, 0, 0);
      repeat (7) drive(1, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 10, 10, 1, 0, 0, 0);
    end
    idle();

    // random traffic on a small register window for dense hazards
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) < 3, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 99) == 0);
    end
    idle();

    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_SRC, 2, source-operand channels checked per cycle.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- LAT_W, 3, width of the per-register latency countdown.
- CNT_W, 16, width of the stall performance counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, single clock; all state updates on its rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- rs_addr_i, in, NUM_SRC*ADDR_W, decode-stage source addresses; channel k at bits [k*ADDR_W +: ADDR_W].
- rs_used_i, in, NUM_SRC, channel k actually reads its register.
- issue_valid_i, in, 1, decode instruction requests issue.
- issue_wr_sig_i, in, 1, the issuing instruction writes rd.
- issue_rd_addr_i, in, ADDR_W, destination register of the issuing instruction.
- issue_lat_i, in, LAT_W, cycles after issue until rd is forwardable.
- wb_valid_i, in, 1, a write-back retires this cycle.
- wb_addr_i, in, ADDR_W, write-back destination.
- stall_o, out, 1, hold decode; the instruction is not issued.
- fwd_valid_o, out, NUM_SRC, channel k must take its operand from the bypass network.
- busy_o, out, NUM_REGS, pending-write bit per register.
- stall_cnt_o, out, CNT_W, saturating count of stalled cycles.

Function
REQ-003 Each register r != 0 SHALL hold a pending bit P[r] and a countdown C[r] (LAT_W bits); register 0 SHALL never be pending.
REQ-004 Issue SHALL be accepted iff issue_valid_i && !stall_o; on acceptance with issue_wr_sig_i=1 and rd != 0: P[rd] <= 1 and C[rd] <= issue_lat_i on the next edge.
REQ-005 Each cycle, every C[r] > 0 not being loaded SHALL decrement by 1, saturating at 0.
REQ-006 wb_valid_i with wb_addr_i != 0 SHALL clear P[wb_addr_i] and C[wb_addr_i] on the next edge.
REQ-007 Simultaneous accepted issue and write-back to the same address SHALL leave the issue result (P=1, C=issue_lat_i).
REQ-008 RAW stall: channel k stalls when rs_used_i[k], rs_addr_k != 0, P[rs_addr_k]=1 and C[rs_addr_k] != 0.
REQ-009 WAW stall: the block SHALL stall when issue_valid_i, issue_wr_sig_i, rd != 0 and P[rd]=1.
REQ-010 stall_o SHALL be the OR of all RAW stalls and the WAW stall, gated by issue_valid_i; it SHALL be combinational from registered state and current inputs.
REQ-011 stall_o SHALL NOT be bypassed by a same-cycle write-back; the stall decision is conservative.
REQ-012 fwd_valid_o[k] SHALL be 1 when rs_used_i[k], rs_addr_k != 0, P[rs_addr_k]=1 and C[rs_addr_k]=0; it is combinational.
REQ-013 busy_o SHALL equal the registered P vector, with bit 0 tied to 0.
REQ-014 stall_cnt_o SHALL increment on every cycle in which stall_o=1 and SHALL saturate at 2**CNT_W-1.
REQ-015 Latency from accepted issue with issue_lat_i=L to the first cycle of fwd_valid_o on a dependent read SHALL be L+1 cycles; L=0 forwards in the next cycle.

Reset
REQ-016 While rst_i=1, asynchronously, all P, all C and stall_cnt_o SHALL be 0.
REQ-017 Consequently, during reset busy_o=0 and fwd_valid_o=0; stall_o=0 for any input.
REQ-018 Reset asserted mid-countdown SHALL discard all pending state; no write-back is required afterwards.

Structure
REQ-019 ADDR_W, LAT_W, CNT_W defaults and any stall-cause encoding constants SHALL live in shared package hazard_pkg.
REQ-020 Per-register state (P, C, load/clear/decrement priority) SHALL be one sub-module, scoreboard_entry, instantiated NUM_REGS-1 times by generate.

Verification
REQ-021 Issue rd=5, lat=2, then decode rs1=5 used -> stall_o=1 for cycles 1-2, fwd_valid_o[0]=1 at cycle 3, stall_cnt_o=2.
REQ-022 Issue rd=7, lat=0, next cycle rs2=7 -> stall_o=0, fwd_valid_o[1]=1; wb 7 -> busy_o[7]=0 the following cycle.
REQ-023 With P[9]=1, issue rd=9 while wb_addr_i=9 in the same cycle -> stall_o=1 (no bypass); the next cycle issue is accepted.
REQ-024 Issue rd=0, lat=3, then rs1=0 used -> busy_o=0, stall_o=0, fwd_valid_o=0.
REQ-025 Issue rd=3, lat=4; assert rst_i at cycle 2 -> busy_o=0 immediately, stall_cnt_o=0, rs1=3 not stalled after release.
REQ-026 Hold a RAW stall for 2**CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt_o stays at 15.
